// File: rtl/rca_if.sv
// rtl/rca_if.sv - operand/result bundle for ripple_carry_adder, modport dut.
// Optional signed-overflow signal ovf is present only when RCA_OVF_EN is defined.
interface rca_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] carry;
  logic             out_valid;
`ifdef RCA_OVF_EN
  logic             ovf;
`endif

  modport dut (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    output sum,
    output cout,
    output carry,
`ifdef RCA_OVF_EN
    output ovf,
`endif
    output out_valid
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - registered WIDTH-bit ripple-carry adder of full-adder cells.
// Signed-overflow output and register compiled in only when RCA_OVF_EN is defined.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  rca_if.dut   bus
);
  logic [WIDTH-1:0] chain_sum;
  logic [WIDTH-1:0] chain_carry;

  // Cell i consumes the carry-out of cell i-1; cell 0 consumes cin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_first
      rca_full_adder u_fa (
        .a     (bus.a[i]),
        .b     (bus.b[i]),
        .c_in  (bus.cin),
        .s     (chain_sum[i]),
        .c_out (chain_carry[i])
      );
    end else begin : g_next
      rca_full_adder u_fa (
        .a     (bus.a[i]),
        .b     (bus.b[i]),
        .c_in  (chain_carry[i-1]),
        .s     (chain_sum[i]),
        .c_out (chain_carry[i])
      );
    end
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;

`ifdef RCA_OVF_EN
  logic chain_ovf;
  logic ovf_q, ovf_d;

  // Overflow is carry into the MSB cell xor carry out of it.
  if (WIDTH == 1) begin : g_ovf_w1
    assign chain_ovf = bus.cin ^ chain_carry[0];
  end else begin : g_ovf_wn
    assign chain_ovf = chain_carry[WIDTH-2] ^ chain_carry[WIDTH-1];
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) ovf_d = chain_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = chain_sum;
      carry_d = chain_carry;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  // cout is the registered carry-out of the MSB cell.
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.cout      = carry_q[WIDTH-1];
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb/tb_ripple_carry_adder.sv - scoreboard bench for ripple_carry_adder, WIDTH=4.
// Overflow checks are compiled in only when RCA_OVF_EN is defined.
module tb_ripple_carry_adder;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] carry;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t exp_q[$];

  rca_if #(.WIDTH(W)) bus ();

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] s, input logic co, input logic [W-1:0] cy,
                       input logic ov);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    e.sum = s; e.cout = co; e.carry = cy; e.ovf = ov;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_outputs(input string name, input logic [W-1:0] s, input logic co,
                             input logic [W-1:0] cy, input logic ov, input logic v);
    chk({name, "_sum"}, 32'(bus.sum), 32'(s));
    chk({name, "_cout"}, 32'(bus.cout), 32'(co));
    chk({name, "_carry"}, 32'(bus.carry), 32'(cy));
    chk({name, "_out_valid"}, 32'(bus.out_valid), 32'(v));
`ifdef RCA_OVF_EN
    chk({name, "_ovf"}, 32'(bus.ovf), 32'(ov));
`else
    if (ov) begin end
`endif
  endtask

  // Monitor: every out_valid cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        chk("mon_sum", 32'(bus.sum), 32'(e.sum));
        chk("mon_cout", 32'(bus.cout), 32'(e.cout));
        chk("mon_carry", 32'(bus.carry), 32'(e.carry));
`ifdef RCA_OVF_EN
        chk("mon_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;

    #2;
    chk_outputs("reset_state", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // a, b, cin -> sum, cout, carry, ovf
    issue(4'b1000, 4'b1110, 1'b0, 4'b0110, 1'b1, 4'b1000, 1'b1);
    issue(4'b1000, 4'b1110, 1'b1, 4'b0111, 1'b1, 4'b1000, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1111, 1'b0);
    issue(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 4'b0111, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_outputs($sformatf("hold%0d", i), 4'b1000, 1'b0, 4'b0111, 1'b1, 1'b0);
    end

    issue(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 4'b0000, 1'b0);
    issue(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    chk("b2b_valid0", 32'(bus.out_valid), 32'd1);
    issue(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("b2b_valid1", 32'(bus.out_valid), 32'd1);
    idle();
    @(negedge clk);
    chk("b2b_valid2", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("b2b_valid_drop", 32'(bus.out_valid), 32'd0);

    // Load a nonzero result, then reset asynchronously mid-cycle.
    issue(4'b1000, 4'b1110, 1'b0, 4'b0110, 1'b1, 4'b1000, 1'b1);
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_outputs("async_reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    bus.in_valid = 1'b1;
    bus.a        = 4'b0101;
    bus.b        = 4'b0011;
    bus.cin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outputs("reset_ignores_in_valid", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("results_seen", 32'(popped), 32'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Registered WIDTH-bit ripple-carry adder built from a chain of single-bit full-adder cells. The cell carry-out of bit i feeds carry-in of bit i+1. The block is a datapath leaf. Operand and result signals are bundled in a SystemVerilog interface, rca_if, and the block connects through its design-side modport, dut. Results are captured in an output register qualified by a valid strobe.

## Interface
Parameters:
- WIDTH, default 4: operand and sum width; legal range 1..32.

Ports. clk and rst are plain module ports. All other signals are members of rca_if, modport dut.
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: operands valid this cycle.
- a, input, WIDTH: operand A, unsigned or two's complement.
- b, input, WIDTH: operand B.
- cin, input, 1: carry into bit 0.
- sum, output, WIDTH: registered sum.
- cout, output, 1: registered carry out of the MSB cell.
- carry, output, WIDTH: registered internal carry vector; carry[i] is the carry-out of cell i, and carry[WIDTH-1] equals cout.
- out_valid, output, 1: sum, cout and carry hold a new result.
- ovf, output, 1: signed overflow. This port exists only with RCA_OVF_EN.

## Operation
- Each cell computes {c_out, s} = a_i + b_i + c_in.
  - Cell 0 takes cin.
  - Cell i takes the carry-out of cell i-1 (i ≥ 1).
- The combinational result always satisfies {cout, sum} = a + b + cin, mod 2^(WIDTH+1). There is no truncation of the carry.
- Output register behaviour on each rising clk edge:
  - If in_valid=1: load sum, cout and carry (and ovf when enabled) from the chain, and set out_valid to 1.
  - If in_valid=0: hold sum, cout, carry and ovf; clear out_valid to 0.
- Result registers hold their value indefinitely until the next valid operand set.
- Consecutive in_valid cycles are accepted back-to-back, one result per cycle. There is no backpressure.
- ovf = carry into MSB XOR carry out of MSB, i.e. carry[WIDTH-2] ^ carry[WIDTH-1]. For WIDTH=1, ovf = cin ^ cout.
- Reset:
  - rst=1 clears sum, cout, carry, ovf and out_valid to 0 immediately, with no clock edge required.
  - While rst is held, in_valid is ignored.
  - An operation in flight when rst asserts is discarded.

## Timing
- Latency: 1 cycle. Operands sampled at edge N appear on the outputs after edge N, with out_valid high for the cycle following edge N.
- out_valid is high for exactly one cycle per accepted operand set.
- The ripple chain is purely combinational between the operand inputs and the output register. Critical path is WIDTH cell delays.
- Reset deassertion is synchronised externally. The first operands are sampled at the first rising edge with rst=0.
- Reset values of all outputs: 0.

## Configuration
- RCA_OVF_EN defined: the ovf port and its register are compiled in, and behave as described above.
- RCA_OVF_EN undefined: no ovf port or register exists, and the interface omits the signal. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with outputs nonzero → sum=0, cout=0, carry=0, out_valid=0 without waiting for a clock edge.
- Basic add, WIDTH=4: a=1000, b=1110, cin=0, in_valid=1 → next cycle sum=0110, cout=1, out_valid=1, ovf=1.
- Carry-in: a=1000, b=1110, cin=1 → sum=0111, cout=1, carry=1000.
- Full ripple: a=1111, b=0000, cin=1 → sum=0000, cout=1, carry=1111, ovf=0.
- Signed overflow and hold:
  - a=0111, b=0001, cin=0 → sum=1000, cout=0, ovf=1.
  - Then drop in_valid for 3 cycles → outputs hold 1000, and out_valid=0.
- Back-to-back: in_valid high for 3 consecutive cycles with operand pairs (3,4,0), (15,15,1), (0,0,0) → results 7/0, 15/1, 0/0 on consecutive cycles, with out_valid continuously 1.
